instruction_memory_loader: RTL

Write-side counterpart of the instruction memory. Receives a program as a byte stream from the debug/UART path, packs each group of 4 bytes into a 32-bit instruction word (MSB first), and writes it into instruction memory at byte addresses 0, 4, 8, …. Loading ends on the HALT word (all ones) or when memory is full. While loading, this block owns the memory write port and the CPU is held off.

---
 rtl/instruction_memory_loader.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/instruction_memory_loader.sv
// Packs a byte stream (MSB first) into instruction words and writes them
// into instruction memory at consecutive word addresses until HALT or full.
module instruction_memory_loader #(
   parameter int               NBITS     = 32,
   parameter int               CELDAS    = 60,
   parameter logic [NBITS-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_start,
   input  logic [7:0]       i_rx_data,
   input  logic             i_rx_done,
   output logic             o_wr_en,
   output logic [NBITS-1:0] o_wr_addr,
   output logic [NBITS-1:0] o_wr_data,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_error,
   output logic [7:0]       o_word_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [NBITS-1:0] ADDR_STEP = NBITS'(4);
   localparam logic [NBITS-1:0] LAST_ADDR = NBITS'(CELDAS - 4);

   state_t            state_r;
   state_t            next_state_s;
   logic [NBITS-1:0]  addr_r;
   logic [1:0]        byte_idx_r;
   // Only the first three bytes need storing; the fourth goes straight to the write register.
   logic [NBITS-9:0]  shift_r;
   logic              wr_en_r;
   logic [NBITS-1:0]  wr_addr_r;
   logic [NBITS-1:0]  wr_data_r;
   logic              busy_r;
   logic              done_r;
   logic              error_r;
   logic [7:0]        word_count_r;

   logic              start_load_s;
   logic              capture_s;
   logic              word_complete_s;
   logic              advance_s;
   logic              overflow_s;

   // Next-state and per-cycle control decisions
   always_comb begin
      next_state_s    = state_r;
      start_load_s    = 1'b0;
      capture_s       = 1'b0;
      word_complete_s = 1'b0;
      advance_s       = 1'b0;
      overflow_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (i_start) begin
               next_state_s = RECV;
               start_load_s = 1'b1;
            end else begin
               next_state_s = IDLE;
            end
         end
         RECV: begin
            capture_s = i_rx_done;
            if (i_rx_done && (byte_idx_r == 2'd3)) begin
               next_state_s    = WRITE;
               word_complete_s = 1'b1;
            end else begin
               next_state_s = RECV;
            end
         end
         WRITE: begin
            // A byte arriving during the write cycle starts the next word.
            capture_s = i_rx_done;
            if (wr_data_r == HALT_WORD) begin
               next_state_s = DONE;
            end else if ((addr_r + ADDR_STEP) > LAST_ADDR) begin
               next_state_s = DONE;
               overflow_s   = 1'b1;
            end else begin
               next_state_s = RECV;
               advance_s    = 1'b1;
            end
         end
         DONE: begin
            if (i_start) begin
               next_state_s = RECV;
               start_load_s = 1'b1;
            end else begin
               next_state_s = DONE;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Datapath: byte packing, address tracking and registered outputs
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         addr_r       <= {NBITS{1'b0}};
         byte_idx_r   <= 2'd0;
         shift_r      <= {(NBITS-8){1'b0}};
         wr_en_r      <= 1'b0;
         wr_addr_r    <= {NBITS{1'b0}};
         wr_data_r    <= {NBITS{1'b0}};
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         error_r      <= 1'b0;
         word_count_r <= 8'd0;
      end else begin
         wr_en_r <= word_complete_s;
         busy_r  <= (next_state_s == RECV) || (next_state_s == WRITE);
         done_r  <= (next_state_s == DONE);
         if (start_load_s) begin
            addr_r       <= {NBITS{1'b0}};
            byte_idx_r   <= 2'd0;
            shift_r      <= {(NBITS-8){1'b0}};
            word_count_r <= 8'd0;
            error_r      <= 1'b0;
         end else begin
            if (capture_s) begin
               shift_r    <= {shift_r[NBITS-17:0], i_rx_data};
               byte_idx_r <= byte_idx_r + 2'd1;
            end
            if (word_complete_s) begin
               wr_addr_r    <= addr_r;
               wr_data_r    <= {shift_r, i_rx_data};
               word_count_r <= word_count_r + 8'd1;
            end
            if (advance_s) begin
               addr_r <= addr_r + ADDR_STEP;
            end
            if (overflow_s) begin
               error_r <= 1'b1;
            end
         end
      end
   end

   assign o_wr_en      = wr_en_r;
   assign o_wr_addr    = wr_addr_r;
   assign o_wr_data    = wr_data_r;
   assign o_busy       = busy_r;
   assign o_done       = done_r;
   assign o_error      = error_r;
   assign o_word_count = word_count_r;

endmodule
